spmmio_rgb_led_bank: RTL

//  Parametrised SPMMIO bank of NUM_LEDS RGB LED channels, the successor to the fixed 4-LED misc block.
//  Per-LED colour, activity-flag enable mask and animation mode: steady, blink, pulse (triangle fade), one-shot flash.
//  A shared prescaler generates the animation tick. Outputs are registered RGB words fed to the board LED drivers.

---
 rtl/spmmio_rgb_led_bank.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/spmmio_rgb_led_bank.sv
// SPMMIO bank of NUM_LEDS RGB channels with steady/blink/pulse/flash animation
// driven by a shared prescaler tick. Bit 0 of every bus is the most significant bit.
module spmmio_rgb_led_bank #(
    parameter int unsigned NUM_LEDS     = 4,
    parameter int unsigned NUM_FLAGS    = 4,
    parameter logic [15:0] PRESCALE_RST = 16'd50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:3]             adr,
    input  logic                   cs,
    input  logic [0:3]             sel,
    input  logic                   we,
    input  logic [0:31]            d,
    output logic [0:31]            q,
    input  logic [0:NUM_FLAGS-1]   flags,
    input  logic [0:24*NUM_LEDS-1] default_rgb,
    output logic [0:24*NUM_LEDS-1] led_rgb
);

    typedef enum logic [1:0] {
        MODE_STEADY = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_PULSE  = 2'b10,
        MODE_FLASH  = 2'b11
    } mode_t;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] lvl);
        logic [15:0] p;
        p = 16'(c) * 16'({1'b0, lvl} + 9'd1);
        return 8'(p >> 8);
    endfunction

    logic                      r_anim_en;
    logic [15:0]               r_prescale;
    logic [15:0]               r_cnt;
    logic                      w_tick;
    logic                      w_wr;
    logic [0:3]                w_flags;
    logic [NUM_LEDS-1:0][31:0] w_rd_val;
    logic [NUM_LEDS-1:0][31:0] w_rd_ctl;
    logic                      w_unused;

    assign w_unused = ^d[4:5];
    assign w_tick   = r_anim_en && (r_cnt == 16'd0);
    assign w_wr     = cs && we && (|sel);

    // Mask bits without a matching flag input never activate a channel.
    for (genvar j = 0; j < 4; j++) begin : g_flag
        if (j < NUM_FLAGS) begin : g_used
            assign w_flags[j] = flags[j];
        end else begin : g_pad
            assign w_flags[j] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_anim_en  <= 1'b1;
            r_prescale <= PRESCALE_RST;
            r_cnt      <= '0;
        end else begin
            if (r_anim_en) begin
                r_cnt <= w_tick ? r_prescale : r_cnt - 16'd1;
            end
            if (w_wr && adr == 4'd0) begin
                if (sel[0]) r_anim_en        <= d[0];
                if (sel[2]) r_prescale[15:8] <= d[16:23];
                if (sel[3]) r_prescale[7:0]  <= d[24:31];
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        localparam logic [3:0] VAL_ADR = 4'(2 + 2 * i);
        localparam logic [3:0] CTL_ADR = 4'(3 + 2 * i);

        logic [23:0] r_value;
        logic [0:3]  r_mask;
        mode_t       r_mode;
        logic [7:0]  r_period;
        logic [7:0]  r_phase;
        logic [7:0]  r_level;
        logic        r_dir;
        logic        r_on;
        logic [23:0] r_led;
        logic [23:0] w_eff;
        logic        w_wr_val;
        logic        w_wr_ctl;
        logic        w_active;
        logic        w_step_end;
        logic [7:0]  w_per1;
        logic [8:0]  w_up;

        assign w_wr_val   = w_wr && (adr == VAL_ADR);
        assign w_wr_ctl   = w_wr && (adr == CTL_ADR);
        assign w_per1     = (r_period == 8'd0) ? 8'd1 : r_period;
        assign w_step_end = ({1'b0, r_phase} + 9'd1) >= {1'b0, w_per1};
        assign w_up       = {1'b0, r_level} + {1'b0, r_period};
        assign w_active   = |(r_mask & w_flags);

        always_comb begin
            w_eff = '0;
            if (r_on) begin
                if (r_mode == MODE_PULSE) begin
                    w_eff = {scale8(r_value[23:16], r_level),
                             scale8(r_value[15:8],  r_level),
                             scale8(r_value[7:0],   r_level)};
                end else begin
                    w_eff = r_value;
                end
            end
        end

        // A register write to this LED in a tick cycle consumes that tick.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_value  <= '0;
                r_mask   <= '0;
                r_mode   <= MODE_STEADY;
                r_period <= '0;
                r_phase  <= '0;
                r_level  <= '0;
                r_dir    <= 1'b0;
                r_on     <= 1'b1;
            end else begin
                if (w_tick && !w_wr_val && !w_wr_ctl) begin
                    case (r_mode)
                        MODE_BLINK: begin
                            if (w_step_end) begin
                                r_phase <= '0;
                                r_on    <= ~r_on;
                            end else begin
                                r_phase <= r_phase + 8'd1;
                            end
                        end
                        MODE_PULSE: begin
                            if (r_period != 8'd0) begin
                                if (!r_dir) begin
                                    if (w_up >= 9'd255) begin
                                        r_level <= 8'd255;
                                        r_dir   <= 1'b1;
                                    end else begin
                                        r_level <= w_up[7:0];
                                    end
                                end else if (r_level <= r_period) begin
                                    r_level <= '0;
                                    r_dir   <= 1'b0;
                                end else begin
                                    r_level <= r_level - r_period;
                                end
                            end
                        end
                        MODE_FLASH: begin
                            if (w_step_end) begin
                                r_mode  <= MODE_STEADY;
                                r_value <= '0;
                                r_phase <= '0;
                            end else begin
                                r_phase <= r_phase + 8'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (w_wr_val) begin
                    if (sel[1]) r_value[23:16] <= d[8:15];
                    if (sel[2]) r_value[15:8]  <= d[16:23];
                    if (sel[3]) r_value[7:0]   <= d[24:31];
                end
                if (w_wr_ctl) begin
                    if (sel[0]) begin
                        r_mask <= d[0:3];
                        r_mode <= mode_t'(d[6:7]);
                    end
                    if (sel[1]) r_period <= d[8:15];
                    r_phase <= '0;
                    r_level <= '0;
                    r_dir   <= 1'b0;
                    r_on    <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_led <= '0;
            end else begin
                r_led <= w_active ? w_eff : default_rgb[24*i +: 24];
            end
        end

        assign led_rgb[24*i +: 24] = r_led;
        assign w_rd_val[i] = {8'h00, r_value};
        assign w_rd_ctl[i] = {r_mask, 2'b00, r_mode, r_period, 16'h0000};
    end

    always_comb begin
        q = '0;
        if (adr == 4'd0) begin
            q = {r_anim_en, 15'd0, r_prescale};
        end
        for (int unsigned k = 0; k < NUM_LEDS; k++) begin
            if (adr == 4'(2 + 2 * k)) q = w_rd_val[k];
            if (adr == 4'(3 + 2 * k)) q = w_rd_ctl[k];
        end
    end

endmodule
